lfsr_gen: RTL
=============

// Module: lfsr_gen
// PURPOSE
//  Parametrised Fibonacci LFSR pseudo-random generator; next generation of the fixed 8-bit LFSR.
//  Adds: configurable width/taps/seed, runtime seed load, step enable, STEPS shifts per cycle,
//  step counter, period-complete flag and all-zero lockup detection.
//  Sits beside game/display logic as the shared random source; one instance per random stream.
// PARAMETERS
//  WIDTH  8      state width in bits, 3..32
//  TAPS   8'h1D  feedback tap mask (WIDTH bits); fb = ^(state & TAPS)
//  SEED   8'hFF  seed-register reset value (WIDTH bits), must be non-zero
//  STEPS  1      single shifts applied per enabled cycle, 1..WIDTH
//  CNT_W  16     step_cnt width
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high; state<=SEED, seed_reg<=SEED
//  clear        in   1      sync: state<=0, step_cnt<=0
//  load         in   1      sync: state<=seed_in, seed_reg<=seed_in, step_cnt<=0
//  seed_in      in   WIDTH  seed value for load
//  en           in   1      sync: advance STEPS shifts this cycle
//  out          out  WIDTH  current state (registered)
//  sout         out  1      LSB shifted out by the last shift of the latest advance
//  step_cnt     out  CNT_W  enabled advances since reset/load/clear; wraps modulo 2^CNT_W
//  period_done  out  1      1-cycle pulse: state after an advance equals seed_reg
//  lockup       out  1      registered: high while state == 0
// BEHAVIOUR
//  - Reset values: out=SEED, seed_reg=SEED, sout=0, step_cnt=0, period_done=0, lockup=0.
//  - Single shift: next = {fb, s[WIDTH-1:1]}, fb = ^(s & TAPS); shifted-out bit = s[0].
//  - Advance = STEPS single shifts chained combinationally; result visible on out 1 cycle after en.
//  - Sync priority: clear > load > en; nothing asserted => hold all regs, period_done=0.
//  - clear: out=0, sout=0, step_cnt=0, lockup=1 next cycle; seed_reg unchanged.
//  - load: out=seed_in next cycle; seed_in==0 accepted (-> lockup=1); load with en: no advance.
//  - en: step_cnt += 1 (wrap 2^CNT_W-1 -> 0, no flag); period_done=1 iff new state == seed_reg.
//  - Defaults (0x1D, 8 bit) maximal: period_done every 255th advance from FF when STEPS=1;
//    STEPS>1 may skip seed_reg: period_done then fires only on an exact match.
//  - lockup = (out == 0), updated with out. reset mid-operation: all regs to reset values at once.
// CONFIGURATION
//  LFSR_LOCKUP_RECOVER_EN defined: en while state==0 reloads state<=seed_reg (not shift),
//    step_cnt increments, lockup falls next cycle; if seed_reg==0, stays 0 and lockup stays 1.
//  Not defined: zero state is absorbing; en shifts 0 -> 0, lockup held until load/reset.
// TESTING
//  1 reset, defaults, STEPS=1: en for 5 cycles -> out 7F,3F,1F,0F,87; sout 1,1,1,1,1.
//  2 defaults: 255 en cycles from FF -> out==FF, period_done pulses once at cnt 255, never before.
//  3 load=1 seed_in=8'hA5 with en=1 -> out=A5, step_cnt=0, no shift; next en shifts from A5.
//  4 clear then en x3 -> lockup=1; without macro out stays 00; with macro out=seed_reg after 1st en.
//  5 STEPS=4: en once from FF -> out==0F (4 single-step result); step_cnt=1.
//  6 async reset mid-run (out=87, cnt=5) between edges -> out=FF, cnt=0 immediately, no clk.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with seed load, multi-step advance, step counter and lockup detect.
// Optional LFSR_LOCKUP_RECOVER_EN: en while the state is zero reloads seed_reg instead of shifting.
module lfsr_gen #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'h1D,
  parameter logic [WIDTH-1:0] SEED = 8'hFF,
  parameter int STEPS = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic [CNT_W-1:0] step_cnt,
  output logic             period_done,
  output logic             lockup
);
  logic [WIDTH-1:0] seed_reg, adv, nxt;
  logic adv_bit, nxt_bit;
  // STEPS single shifts chained; adv_bit is the bit dropped by the last one
  always_comb begin
    adv = out;
    adv_bit = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      adv_bit = adv[0];
      adv = {^(adv & TAPS), adv[WIDTH-1:1]};
    end
  end
`ifdef LFSR_LOCKUP_RECOVER_EN
  assign nxt = (out == '0) ? seed_reg : adv;
  assign nxt_bit = (out == '0) ? 1'b0 : adv_bit;
`else
  assign nxt = adv;
  assign nxt_bit = adv_bit;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= SEED;
      seed_reg <= SEED;
      sout <= 1'b0;
      step_cnt <= '0;
      period_done <= 1'b0;
      lockup <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (clear) begin
        out <= '0;
        sout <= 1'b0;
        step_cnt <= '0;
        lockup <= 1'b1;
      end else if (load) begin
        out <= seed_in;
        seed_reg <= seed_in;
        step_cnt <= '0;
        lockup <= (seed_in == '0);
      end else if (en) begin
        out <= nxt;
        sout <= nxt_bit;
        step_cnt <= step_cnt + 1'b1;
        period_done <= (nxt == seed_reg);
        lockup <= (nxt == '0);
      end
    end
  end
endmodule
